fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage. It generates the fetch stage's stall, flush, flush_pc, next_pc and req inputs from the following sources:
- decode hazards
- execute-stage redirects (branch/jump)
- halt/resume requests
- fetch readiness

It owns the post-reset boot sequence, redirect bubbles, halt state and a stall watchdog. It sits between the fetch stage and the decode/execute hazard logic.

---
 rtl/all_pkgs.sv | 15 +
 rtl/fetch_ctrl_stall_watchdog.sv | 39 +++
 rtl/fetch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/all_pkgs.sv
// Shared types and constants for the front-end pipeline blocks.
// Holds the datapath width, instruction size and fetch controller state encoding.
package all_pkgs;

  localparam int WIDTH       = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } fetch_ctrl_state_t;

endpackage

// File: rtl/fetch_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles, sets a sticky flag at STALL_TIMEOUT.
// The flag is registered and is visible the cycle after the Nth counted cycle. It clears only on rst.
module stall_watchdog #(
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam int CW = $clog2(STALL_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  always_comb begin
    cnt_d  = '0;
    flag_d = flag_q;
    if (count_en_i) begin
      // Saturate so a very long stall cannot wrap back below the threshold.
      cnt_d = (cnt_q == CW'(STALL_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
      if (cnt_d == CW'(STALL_TIMEOUT)) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o = flag_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing controller: boot, redirect bubbles, halt and stall watchdog.
// flush/flush_pc/halted are registered (1-cycle latency). Perf counters are enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import all_pkgs::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC      = 32'h0000_0000,
  parameter int               BOOT_CYCLES   = 2,
  parameter int               STALL_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             if_ready,
  input  logic             hazard_stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             halt_req,
  input  logic             resume,
  output logic             stall,
  output logic             flush,
  output logic [WIDTH-1:0] flush_pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             req,
  output logic             halted,
  output logic             misalign_err,
`ifdef FETCH_CTRL_PERF_EN
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_redirects,
  output logic [31:0]      perf_halts,
`endif
  output logic             stall_timeout
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int AW = $clog2(INSTR_BYTES);

  fetch_ctrl_state_t state_q, state_d;
  logic [BW-1:0]     boot_cnt_q, boot_cnt_d;
  logic              flush_q;
  logic [WIDTH-1:0]  flush_pc_q, flush_pc_d;
  logic              halted_q;
  logic              misalign_q, misalign_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  pend_pc_q, pend_pc_d;
  logic              rd_aligned;

  assign rd_aligned = (redirect_pc[AW-1:0] == '0);
  assign next_pc    = fetch_pc + WIDTH'(INSTR_BYTES);

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    flush_pc_d = flush_pc_q;
    misalign_d = misalign_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    stall      = 1'b0;
    req        = 1'b0;
    unique case (state_q)
      BOOT: begin
        stall = 1'b1;
        if (boot_cnt_q == BW'(BOOT_CYCLES - 1)) begin
          state_d    = REDIRECT;
          flush_pc_d = RESET_PC;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end
      REDIRECT: begin
        state_d = RUN;
        if (redirect_valid) begin
          if (rd_aligned) begin
            state_d    = REDIRECT;
            flush_pc_d = redirect_pc;
          end else begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end
        end
      end
      RUN: begin
        req   = 1'b1;
        stall = hazard_stall | ~if_ready;
        if (redirect_valid) begin
          if (rd_aligned) begin
            state_d    = REDIRECT;
            flush_pc_d = redirect_pc;
          end else begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end
        end else if (halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        stall = 1'b1;
        if (redirect_valid) begin
          if (rd_aligned) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end else begin
            misalign_d = 1'b1;
          end
        end
        // A redirect arriving together with resume is honoured as the latest one.
        if (resume) begin
          if (pend_d) begin
            state_d    = REDIRECT;
            flush_pc_d = pend_pc_d;
            pend_d     = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= RESET_PC;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      flush_q    <= (state_d == REDIRECT);
      flush_pc_q <= flush_pc_d;
      halted_q   <= (state_d == HALT);
      misalign_q <= misalign_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

  stall_watchdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .count_en_i ((state_q == RUN) && stall),
    .timeout_o  (stall_timeout)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_redir_q, perf_halt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_redir_q <= '0;
      perf_halt_q  <= '0;
    end else begin
      if ((state_q == RUN) && stall && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
      // The boot flush is not a control-flow redirect.
      if ((state_d == REDIRECT) && (state_q != BOOT) && (perf_redir_q != '1))
        perf_redir_q <= perf_redir_q + 32'd1;
      if ((state_d == HALT) && (state_q != HALT) && (perf_halt_q != '1))
        perf_halt_q <= perf_halt_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_redirects    = perf_redir_q;
  assign perf_halts        = perf_halt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, redirects, priority, halt/resume, watchdog, wrap and mid-run reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        if_ready, hazard_stall, redirect_valid, halt_req, resume;
  logic [31:0] redirect_pc;
  logic        stall, flush, req, halted, misalign_err, stall_timeout;
  logic [31:0] flush_pc, next_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_halts;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .BOOT_CYCLES  (2),
    .STALL_TIMEOUT(1024)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_pc      (fetch_pc),
    .if_ready      (if_ready),
    .hazard_stall  (hazard_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .resume        (resume),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .next_pc       (next_pc),
    .req           (req),
    .halted        (halted),
    .misalign_err  (misalign_err),
`ifdef FETCH_CTRL_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_redirects   (perf_redirects),
    .perf_halts       (perf_halts),
`endif
    .stall_timeout (stall_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1; fetch_pc = 32'h0; if_ready = 1'b1; hazard_stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; resume = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_stall", stall, 1);
    check("rst_req", req, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 32'h0);
    check("rst_halted", halted, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_timeout", stall_timeout, 0);

    // Boot: two stall cycles, then one flush to RESET_PC, then RUN
    rst = 1'b0; #1;
    check("boot1_stall", stall, 1);
    check("boot1_req", req, 0);
    tick();
    check("boot2_stall", stall, 1);
    check("boot2_flush", flush, 0);
    tick();
    check("boot_flush", flush, 1);
    check("boot_flush_pc", flush_pc, 32'h0);
    check("boot_redir_req", req, 0);
    check("boot_redir_stall", stall, 0);
    tick();
    check("run_req", req, 1);
    check("run_flush", flush, 0);
    check("run_next_pc", next_pc, 32'h4);

    // Single redirect
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; #1;
    check("redir_flush", flush, 1);
    check("redir_flush_pc", flush_pc, 32'h100);
    check("redir_req", req, 0);
    tick();
    check("redir_back_run", req, 1);
    check("redir_back_flush", flush, 0);

    // Back-to-back redirects
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    check("b2b_first_pc", flush_pc, 32'h100);
    redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0; #1;
    check("b2b_second_flush", flush, 1);
    check("b2b_second_pc", flush_pc, 32'h200);
    tick();
    check("b2b_run_flush", flush, 0);

    // Priority: redirect over halt over hazard
    redirect_valid = 1'b1; redirect_pc = 32'h40; halt_req = 1'b1; hazard_stall = 1'b1; #1;
    check("prio_run_stall", stall, 1);
    tick();
    redirect_valid = 1'b0; halt_req = 1'b0; hazard_stall = 1'b0; #1;
    check("prio_flush", flush, 1);
    check("prio_flush_pc", flush_pc, 32'h40);
    check("prio_no_halt", halted, 0);
    tick();

    // if_ready low stalls in RUN
    if_ready = 1'b0; #1;
    check("not_ready_stall", stall, 1);
    if_ready = 1'b1; #1;
    check("ready_no_stall", stall, 0);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0; #1;
    check("mis_err", misalign_err, 1);
    check("mis_halted", halted, 1);
    check("mis_no_flush", flush, 0);
    check("mis_stall", stall, 1);
    check("mis_req", req, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0; #1;
    check("mis_resume_run", req, 1);
    check("mis_resume_halted", halted, 0);
    check("mis_sticky", misalign_err, 1);

    // Halt, pending redirect, resume
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; #1;
    check("halt_halted", halted, 1);
    check("halt_stall", stall, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0; #1;
    check("halt_pend_halted", halted, 1);
    check("halt_pend_no_flush", flush, 0);
    resume = 1'b1;
    tick();
    resume = 1'b0; #1;
    check("resume_flush", flush, 1);
    check("resume_flush_pc", flush_pc, 32'h300);
    check("resume_halted", halted, 0);
    tick();
    check("resume_run_req", req, 1);

    // halt_req together with resume in HALT: resume wins
    halt_req = 1'b1;
    tick();
    resume = 1'b1; #1;
    tick();
    halt_req = 1'b0; resume = 1'b0; #1;
    check("resume_wins_halted", halted, 0);
    check("resume_wins_req", req, 1);

    // Watchdog: 1024 consecutive stall cycles in RUN
    hazard_stall = 1'b1;
    repeat (1023) tick();
    check("wd_before", stall_timeout, 0);
    tick();
    check("wd_set", stall_timeout, 1);
    hazard_stall = 1'b0;
    tick();
    check("wd_sticky", stall_timeout, 1);
    check("wd_stall_low", stall, 0);

    // next_pc wraparound
    fetch_pc = 32'hFFFF_FFFC; #1;
    check("wrap_next_pc", next_pc, 32'h0);
    fetch_pc = 32'h0000_1000; #1;
    check("next_pc_1000", next_pc, 32'h1004);

    // Reset while flush is high
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0; #1;
    check("pre_rst_flush", flush, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_flush", flush, 0);
    check("rst_mid_stall", stall, 1);
    check("rst_mid_timeout", stall_timeout, 0);
    check("rst_mid_misalign", misalign_err, 0);
    rst = 1'b0;
    tick(); tick();
    check("reboot_flush", flush, 1);
    check("reboot_flush_pc", flush_pc, 32'h0);
    tick();

    // Reset while a redirect is pending in HALT: it must be discarded
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rst_halt_halted", halted, 0);
    check("rst_halt_req", req, 0);
    tick();
    check("reboot2_stall", stall, 1);
    tick();
    check("reboot2_flush_pc", flush_pc, 32'h0);
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; resume = 1'b1;
    tick();
    resume = 1'b0; #1;
    check("pend_discarded_flush", flush, 0);
    check("pend_discarded_run", req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
